// File: rtl/wash_cycle_sequencer.sv
// Washing-machine program sequencer: timed FILL/HEAT/WASH/DRAIN/RINSE/SPIN phases
// driven by an external tick, with pause, door interlock and heat timeout.
module wash_cycle_sequencer #(
  parameter int FILL_TIME  = 8,
  parameter int WASH_TIME  = 20,
  parameter int DRAIN_TIME = 6,
  parameter int RINSE_TIME = 10,
  parameter int SPIN_TIME  = 12,
  parameter int HEAT_MAX   = 30
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       start,
  input  logic       pause,
  input  logic       door_closed,
  input  logic [2:0] wash_mode,
  input  logic [5:0] target_temp,
  input  logic [5:0] water_temp,
  output logic       door_lock,
  output logic       water_valve,
  output logic       heater_on,
  output logic       motor_on,
  output logic       spin_fast,
  output logic       drain_pump,
  output logic       done,
  output logic       error,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_FILL  = 4'd1,
    S_HEAT  = 4'd2,
    S_WASH  = 4'd3,
    S_DRAIN = 4'd4,
    S_RINSE = 4'd5,
    S_SPIN  = 4'd6,
    S_DONE  = 4'd7,
    S_ERROR = 4'd8
  } state_t;

  localparam logic [7:0] FILL_T     = 8'(FILL_TIME);
  localparam logic [7:0] WASH_T     = 8'(WASH_TIME);
  localparam logic [7:0] DRAIN_T    = 8'(DRAIN_TIME);
  localparam logic [7:0] RINSE_T    = 8'(RINSE_TIME);
  localparam logic [7:0] SPIN_FULL  = 8'(SPIN_TIME);
  localparam logic [7:0] SPIN_HALF  = 8'(SPIN_TIME >> 1);
  localparam logic [7:0] HEAT_T     = 8'(HEAT_MAX);

  state_t     state_q, state_d;
  logic [7:0] timer_q, timer_d;
  logic [2:0] mode_q, mode_d;
  logic [5:0] target_q, target_d;
  logic       start_q;
  logic       armed_q;
  // {door_lock, water_valve, heater_on, motor_on, spin_fast, drain_pump, done, error}
  logic [7:0] outs_q, outs_d;

  logic       start_edge, locked, step, expire, temp_ok, run;
  logic [7:0] spin_len;

  always_comb begin
    // armed_q blocks a start level that was already high when reset released
    start_edge = start & ~start_q & armed_q;
    locked     = (state_q >= S_FILL) && (state_q <= S_SPIN);
    run        = ~pause;
    step       = tick & run;
    expire     = step && (timer_q == 8'd1);
    temp_ok    = run && (water_temp >= target_q);
    spin_len   = ((mode_q == 3'd5) || (mode_q == 3'd6)) ? SPIN_HALF : SPIN_FULL;

    state_d  = state_q;
    timer_d  = timer_q;
    mode_d   = mode_q;
    target_d = target_q;

    if (locked && step && !expire) timer_d = timer_q - 8'd1;

    case (state_q)
      S_IDLE: begin
        if (start_edge && door_closed) begin
          state_d  = S_FILL;
          timer_d  = FILL_T;
          mode_d   = wash_mode;
          target_d = target_temp;
        end
      end
      S_FILL:  if (expire) begin state_d = S_HEAT; timer_d = HEAT_T; end
      S_HEAT: begin
        if (temp_ok) begin
          state_d = S_WASH;
          timer_d = WASH_T;
        end else if (expire) begin
          state_d = S_ERROR;
        end
      end
      S_WASH:  if (expire) begin state_d = S_DRAIN; timer_d = DRAIN_T; end
      S_DRAIN: begin
        if (expire) begin
          if (mode_q == 3'd3) begin
            state_d = S_SPIN;
            timer_d = spin_len;
          end else begin
            state_d = S_RINSE;
            timer_d = RINSE_T;
          end
        end
      end
      S_RINSE: if (expire) begin state_d = S_SPIN; timer_d = spin_len; end
      S_SPIN:  if (expire) state_d = S_DONE;
      S_DONE:  if (!door_closed) state_d = S_IDLE;
      S_ERROR: state_d = S_ERROR;
      default: state_d = S_ERROR;
    endcase

    // Door interlock overrides every other transition, including pause
    if (locked && !door_closed) state_d = S_ERROR;
  end

  always_comb begin
    outs_d = 8'b0;
    case (state_q)
      S_FILL:  outs_d = {1'b1, run, 6'b0};
      S_HEAT:  outs_d = {2'b10, run, 5'b0};
      S_WASH:  outs_d = {3'b100, run, 4'b0};
      S_DRAIN: outs_d = {5'b10000, run, 2'b0};
      S_RINSE: outs_d = {1'b1, run, 1'b0, run, 4'b0};
      S_SPIN:  outs_d = {3'b100, run, run, run, 2'b0};
      S_DONE:  outs_d = 8'b0000_0010;
      S_ERROR: outs_d = 8'b0000_0001;
      default: outs_d = 8'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      timer_q  <= 8'd0;
      mode_q   <= 3'd0;
      target_q <= 6'd0;
      start_q  <= 1'b0;
      armed_q  <= 1'b0;
      outs_q   <= 8'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      mode_q   <= mode_d;
      target_q <= target_d;
      start_q  <= start;
      if (!start) armed_q <= 1'b1;
      outs_q   <= outs_d;
    end
  end

  assign {door_lock, water_valve, heater_on, motor_on,
          spin_fast, drain_pump, done, error} = outs_q;
  assign state = state_q;

endmodule
